// File: rtl/alu_pkg.sv
// Shared types for the RV32IM execute-stage ALU: op codes, FSM states, funct3 values.
// ALU_MDU_DIV_EN selects whether the divide ops are iterative (present) or illegal.
package alu_pkg;

    localparam int OP_W = 5;

    typedef enum logic [OP_W-1:0] {
        OP_ADD     = 5'd0,
        OP_SUB     = 5'd1,
        OP_SLL     = 5'd2,
        OP_SLT     = 5'd3,
        OP_SLTU    = 5'd4,
        OP_XOR     = 5'd5,
        OP_SRL     = 5'd6,
        OP_SRA     = 5'd7,
        OP_OR      = 5'd8,
        OP_AND     = 5'd9,
        OP_MUL     = 5'd10,
        OP_MULH    = 5'd11,
        OP_MULHSU  = 5'd12,
        OP_MULHU   = 5'd13,
        OP_DIV     = 5'd14,
        OP_DIVU    = 5'd15,
        OP_REM     = 5'd16,
        OP_REMU    = 5'd17,
        OP_ILLEGAL = 5'd18
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    function automatic logic is_mul_op(alu_op_e op);
        case (op)
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    function automatic logic is_iterative(alu_op_e op);
        case (op)
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: return 1'b1;
`ifdef ALU_MDU_DIV_EN
            OP_DIV, OP_DIVU, OP_REM, OP_REMU:     return 1'b1;
`endif
            default:                             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of ALUOp/funct3/funct7 bits into an alu_op_e code.
// Without ALU_MDU_DIV_EN the divide/remainder encodings decode as OP_ILLEGAL.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       funct7b0,
    input  logic       opb5,
    output alu_op_e    op
);

    // Map instruction fields onto the internal op code
    always_comb begin
        op = OP_ILLEGAL;
        case (alu_op)
            2'b00: op = OP_ADD;
            2'b01: op = OP_SUB;
            2'b10: begin
                if (opb5 && funct7b0) begin
                    case (funct3)
                        F3_MUL:    op = OP_MUL;
                        F3_MULH:   op = OP_MULH;
                        F3_MULHSU: op = OP_MULHSU;
                        F3_MULHU:  op = OP_MULHU;
`ifdef ALU_MDU_DIV_EN
                        F3_DIV:    op = OP_DIV;
                        F3_DIVU:   op = OP_DIVU;
                        F3_REM:    op = OP_REM;
                        F3_REMU:   op = OP_REMU;
`endif
                        default:   op = OP_ILLEGAL;
                    endcase
                end else begin
                    case (funct3)
                        // I-type immediates carry junk in bit 5, so sub needs opb5
                        F3_ADD:  op = (opb5 && funct7b5) ? OP_SUB : OP_ADD;
                        F3_SLL:  op = OP_SLL;
                        F3_SLT:  op = OP_SLT;
                        F3_SLTU: op = OP_SLTU;
                        F3_XOR:  op = OP_XOR;
                        F3_SR:   op = funct7b5 ? OP_SRA : OP_SRL;
                        F3_OR:   op = OP_OR;
                        F3_AND:  op = OP_AND;
                        default: op = OP_ILLEGAL;
                    endcase
                end
            end
            default: op = OP_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/alu_mdu_unit.sv
// RV32IM execute-stage ALU with valid/ready handshake; mul (and div/rem when
// ALU_MDU_DIV_EN is defined) iterate one bit per cycle, all other ops take one cycle.
module alu_mdu_unit
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      ALUOp,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic            funct7b0,
    input  logic            opb5,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal,
    output logic            busy
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam int SH_W  = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    alu_state_e        state_r, state_nx_s;
    alu_op_e           op_s, op_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [2*XLEN-1:0] acc_r, acc_nx_s, prod_s;
    logic [XLEN-1:0]   mcand_r;
    logic              neg_r;
    logic [XLEN-1:0]   result_r, single_res_s, fix_res_s;
    logic              zero_r, illegal_r;
    logic              accept_s, iter_s, last_s;
    logic              sa_s, sb_s;
    logic [XLEN-1:0]   mag_a_s, mag_b_s;
    logic [XLEN:0]     add_s;
`ifdef ALU_MDU_DIV_EN
    logic              sa_r, div0_r;
    logic [XLEN:0]     shift_s, diff_s;
    logic [XLEN-1:0]   quo_s, rem_s;
`endif

    alu_op_decode u_decode (
        .alu_op   (ALUOp),
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .funct7b0 (funct7b0),
        .opb5     (opb5),
        .op       (op_s)
    );

    assign in_ready  = (state_r == ST_IDLE) || ((state_r == ST_DONE) && out_ready);
    assign accept_s  = in_valid && in_ready;
    assign iter_s    = is_iterative(op_s);
    assign last_s    = (state_r == ST_CALC) && (cnt_r == CNT_LAST);
    assign out_valid = (state_r == ST_DONE);
    assign busy      = (state_r == ST_CALC);
    assign result    = result_r;
    assign zero      = zero_r;
    assign illegal   = illegal_r;

    // Next-state logic for IDLE/CALC/DONE
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_nx_s = iter_s ? ST_CALC : ST_DONE;
                else          state_nx_s = ST_IDLE;
            end
            ST_CALC: begin
                if (last_s) state_nx_s = ST_DONE;
                else        state_nx_s = ST_CALC;
            end
            ST_DONE: begin
                if (accept_s)       state_nx_s = iter_s ? ST_CALC : ST_DONE;
                else if (out_ready) state_nx_s = ST_IDLE;
                else                state_nx_s = ST_DONE;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Single-cycle ALU datapath
    always_comb begin
        single_res_s = {XLEN{1'b0}};
        case (op_s)
            OP_ADD:  single_res_s = src_a + src_b;
            OP_SUB:  single_res_s = src_a - src_b;
            OP_SLL:  single_res_s = src_a << src_b[SH_W-1:0];
            OP_SLT:  single_res_s = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OP_SLTU: single_res_s = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            OP_XOR:  single_res_s = src_a ^ src_b;
            OP_SRL:  single_res_s = src_a >> src_b[SH_W-1:0];
            OP_SRA:  single_res_s = $signed(src_a) >>> src_b[SH_W-1:0];
            OP_OR:   single_res_s = src_a | src_b;
            OP_AND:  single_res_s = src_a & src_b;
            default: single_res_s = {XLEN{1'b0}};
        endcase
    end

    // Operand signedness and magnitudes for the iterative unit
    always_comb begin
        sa_s = 1'b0;
        sb_s = 1'b0;
        case (op_s)
            OP_MUL, OP_MULH: begin
                sa_s = src_a[XLEN-1];
                sb_s = src_b[XLEN-1];
            end
            OP_MULHSU: sa_s = src_a[XLEN-1];
`ifdef ALU_MDU_DIV_EN
            OP_DIV, OP_REM: begin
                sa_s = src_a[XLEN-1];
                sb_s = src_b[XLEN-1];
            end
`endif
            default: begin
                sa_s = 1'b0;
                sb_s = 1'b0;
            end
        endcase
        mag_a_s = sa_s ? -src_a : src_a;
        mag_b_s = sb_s ? -src_b : src_b;
    end

    // One shift-add (multiply) or restoring-subtract (divide) step
    always_comb begin
        add_s = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, mcand_r} : {(XLEN+1){1'b0}});
`ifdef ALU_MDU_DIV_EN
        shift_s = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
        diff_s  = shift_s - {1'b0, mcand_r};
        if (is_mul_op(op_r))  acc_nx_s = {add_s, acc_r[XLEN-1:1]};
        else if (!diff_s[XLEN]) acc_nx_s = {diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
        else                  acc_nx_s = {shift_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
`else
        if (is_mul_op(op_r)) acc_nx_s = {add_s, acc_r[XLEN-1:1]};
        else                 acc_nx_s = acc_r;
`endif
    end

    // Sign fix-up applied to the final step's accumulator
    always_comb begin
        prod_s    = neg_r ? -acc_nx_s : acc_nx_s;
`ifdef ALU_MDU_DIV_EN
        quo_s     = div0_r ? {XLEN{1'b1}} : (neg_r ? -acc_nx_s[XLEN-1:0] : acc_nx_s[XLEN-1:0]);
        rem_s     = sa_r ? -acc_nx_s[2*XLEN-1:XLEN] : acc_nx_s[2*XLEN-1:XLEN];
`endif
        fix_res_s = {XLEN{1'b0}};
        case (op_r)
            OP_MUL:                      fix_res_s = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res_s = prod_s[2*XLEN-1:XLEN];
`ifdef ALU_MDU_DIV_EN
            OP_DIV:  fix_res_s = quo_s;
            OP_DIVU: fix_res_s = acc_nx_s[XLEN-1:0];
            OP_REM:  fix_res_s = rem_s;
            OP_REMU: fix_res_s = acc_nx_s[2*XLEN-1:XLEN];
`endif
            default: fix_res_s = {XLEN{1'b0}};
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_r <= ST_IDLE;
        else          state_r <= state_nx_s;
    end

    // Operand, accumulator, counter and result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_r      <= OP_ADD;
            cnt_r     <= {CNT_W{1'b0}};
            acc_r     <= {(2*XLEN){1'b0}};
            mcand_r   <= {XLEN{1'b0}};
            neg_r     <= 1'b0;
            result_r  <= {XLEN{1'b0}};
            zero_r    <= 1'b0;
            illegal_r <= 1'b0;
`ifdef ALU_MDU_DIV_EN
            sa_r      <= 1'b0;
            div0_r    <= 1'b0;
`endif
        end else if (accept_s) begin
            op_r  <= op_s;
            cnt_r <= {CNT_W{1'b0}};
            if (iter_s) begin
                neg_r <= sa_s ^ sb_s;
                if (is_mul_op(op_s)) begin
                    acc_r   <= {{XLEN{1'b0}}, mag_b_s};
                    mcand_r <= mag_a_s;
                end else begin
                    acc_r   <= {{XLEN{1'b0}}, mag_a_s};
                    mcand_r <= mag_b_s;
                end
`ifdef ALU_MDU_DIV_EN
                sa_r   <= sa_s;
                div0_r <= (src_b == {XLEN{1'b0}});
`endif
            end else begin
                result_r  <= single_res_s;
                zero_r    <= (single_res_s == {XLEN{1'b0}});
                illegal_r <= (op_s == OP_ILLEGAL);
            end
        end else if (state_r == ST_CALC) begin
            acc_r <= acc_nx_s;
            cnt_r <= cnt_r + CNT_W'(1);
            if (last_s) begin
                result_r  <= fix_res_s;
                zero_r    <= (fix_res_s == {XLEN{1'b0}});
                illegal_r <= 1'b0;
            end else begin
                result_r  <= result_r;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: tb/tb_alu_mdu_unit.sv
// Scoreboard bench for alu_mdu_unit: directed ops push expectations, a monitor
// pops and compares on every out_valid&out_ready; ALU_MDU_DIV_EN selects div checks.
module tb_alu_mdu_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [1:0]      ALUOp = 2'b00;
    logic [2:0]      funct3 = 3'b000;
    logic            funct7b5 = 1'b0;
    logic            funct7b0 = 1'b0;
    logic            opb5 = 1'b0;
    logic [XLEN-1:0] src_a = '0;
    logic [XLEN-1:0] src_b = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;
    logic            busy;

    typedef struct packed {
        logic [XLEN-1:0] res;
        logic            z;
        logic            ill;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   total = 0;
    int   bad = 0;
    int   lat, bcnt;
    logic seen;

    always #5 clk = ~clk;

    alu_mdu_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .ALUOp(ALUOp), .funct3(funct3), .funct7b5(funct7b5), .funct7b0(funct7b0),
        .opb5(opb5), .src_a(src_a), .src_b(src_b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal),
        .busy(busy)
    );

    // Monitor: every completed output handshake is checked against the queue head
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output: got result=%h with no pending op", result);
            end else begin
                e = exp_q.pop_front();
                if ({result, zero, illegal} !== e) begin
                    bad++;
                    $display("FAIL scoreboard: got res=%h z=%b ill=%b, want res=%h z=%b ill=%b",
                             result, zero, illegal, e.res, e.z, e.ill);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge
    task automatic send(input logic [1:0] aop, input logic [2:0] f3, input logic f7b5,
                        input logic f7b0, input logic ob5, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic exp_ill, input logic push);
        int n;
        if (push) exp_q.push_back({exp_res, (exp_res == 32'd0), exp_ill});
        ALUOp = aop; funct3 = f3; funct7b5 = f7b5; funct7b0 = f7b0; opb5 = ob5;
        src_a = a; src_b = b; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles, want 1", in_ready, n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts cycles from accept to out_valid and busy cycles in between
    task automatic wait_out(output int l, output int bc);
        l = 0;
        bc = 0;
        do begin
            @(negedge clk);
            l++;
            if (busy) bc++;
        end while (!out_valid && l < 100);
        sync();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
        sync();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        sync();

        send(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd5, 32'd7, 32'd12, 1'b0, 1'b1);
        wait_out(lat, bcnt);
        check("add_latency", lat, 32'd1);

        send(2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 32'd3, 32'd3, 32'd0, 1'b0, 1'b1);
        send(2'b10, 3'b101, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b1);
        send(2'b10, 3'b101, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1'b1);
        send(2'b10, 3'b001, 1'b0, 1'b0, 1'b1, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 1'b1);
        send(2'b10, 3'b001, 1'b0, 1'b0, 1'b1, 32'd1, 32'd33, 32'd2, 1'b0, 1'b1);
        send(2'b10, 3'b010, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0, 1'b1);
        send(2'b10, 3'b011, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1'b1);
        send(2'b10, 3'b100, 1'b0, 1'b0, 1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b1);
        send(2'b10, 3'b110, 1'b0, 1'b0, 1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b1);
        send(2'b10, 3'b111, 1'b0, 1'b0, 1'b1, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b1);
        send(2'b10, 3'b000, 1'b1, 1'b0, 1'b0, 32'd10, 32'h0000_0400, 32'h0000_040A, 1'b0, 1'b1);
        send(2'b11, 3'b000, 1'b0, 1'b0, 1'b1, 32'd5, 32'd7, 32'd0, 1'b1, 1'b1);
        send(2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 32'd2, 32'd3, 32'hFFFF_FFFF, 1'b0, 1'b1);
        drain();

        send(2'b10, 3'b001, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0, 1'b1);
        wait_out(lat, bcnt);
        check("mulh_latency", lat, 32'd33);
        check("mulh_busy_cycles", bcnt, 32'd32);
        send(2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 1'b0, 1'b1);
        send(2'b10, 3'b010, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        send(2'b10, 3'b011, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b1);
        send(2'b10, 3'b001, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 1'b1);
        send(2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 32'd0, 32'h1234_5678, 32'd0, 1'b0, 1'b1);
        drain();

`ifdef ALU_MDU_DIV_EN
        send(2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);
        wait_out(lat, bcnt);
        check("div_latency", lat, 32'd33);
        send(2'b10, 3'b110, 1'b0, 1'b1, 1'b1, 32'd7, 32'd0, 32'd7, 1'b0, 1'b1);
        send(2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1);
        send(2'b10, 3'b110, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
        send(2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 1'b1);
        send(2'b10, 3'b110, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b1);
        send(2'b10, 3'b101, 1'b0, 1'b1, 1'b1, 32'd7, 32'd2, 32'd3, 1'b0, 1'b1);
        send(2'b10, 3'b111, 1'b0, 1'b1, 1'b1, 32'd7, 32'd2, 32'd1, 1'b0, 1'b1);
        send(2'b10, 3'b101, 1'b0, 1'b1, 1'b1, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);
`else
        send(2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 32'd7, 32'd0, 32'd0, 1'b1, 1'b1);
        wait_out(lat, bcnt);
        check("div_illegal_latency", lat, 32'd1);
        send(2'b10, 3'b111, 1'b0, 1'b1, 1'b1, 32'd7, 32'd2, 32'd0, 1'b1, 1'b1);
`endif
        drain();

        out_ready = 1'b0;
        send(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd10, 32'd20, 32'd30, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_result_stable", result, 32'd30);
            check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
            check("bp_out_valid_held", {31'd0, out_valid}, 32'd1);
        end
        sync();
        out_ready = 1'b1;
        send(2'b10, 3'b100, 1'b0, 1'b0, 1'b1, 32'd6, 32'd3, 32'd5, 1'b0, 1'b1);
        wait_out(lat, bcnt);
        check("b2b_latency", lat, 32'd1);
        drain();

        send(2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 32'd3, 32'd4, 32'd12, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_output", {31'd0, seen}, 32'd0);
        sync();
        send(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1, 32'd2, 1'b0, 1'b1);
        wait_out(lat, bcnt);
        check("post_abort_latency", lat, 32'd1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
